// File: rtl/branch_redirect_if.sv
// rtl/branch_redirect_if.sv - resolve/redirect handshake bundle between execute, branch_redirect and fetch
interface branch_redirect_if #(
  parameter int XLEN = 32
);
  logic            resolve_valid;
  logic            resolve_ready;
  logic            resolve_taken;
  logic            resolve_pred;
  logic [XLEN-1:0] resolve_pc;
  logic [XLEN-1:0] resolve_target;
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;

  // Driver side: execute presents resolutions, fetch answers redirects.
  modport master (
    output resolve_valid, resolve_taken, resolve_pred, resolve_pc, resolve_target, redir_ready,
    input  resolve_ready, redir_valid, redir_pc
  );

  // Block side: consumes resolutions, issues redirects.
  modport slave (
    input  resolve_valid, resolve_taken, resolve_pred, resolve_pc, resolve_target, redir_ready,
    output resolve_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/branch_redirect.sv
// rtl/branch_redirect.sv - branch resolution consumer: redirect, flush and misaligned-target exception (stats: BRANCH_REDIRECT_STATS_EN)
module branch_redirect #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_STEP      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  branch_redirect_if.slave  bus,
  output logic              flush_if,
  output logic              flush_id,
  output logic              misalign_exc,
  output logic [XLEN-1:0]   exc_addr,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [3:0]      flush_cnt, flush_cnt_nxt;
  logic [XLEN-1:0] redir_pc_q, redir_pc_nxt;
  logic            accept;
  logic            misaligned;
  logic            mispredict;
  logic [XLEN-1:0] next_pc;
  logic            ready_c;
  logic            redir_valid_c;
  logic            flush_c;

  // A taken branch to a non-word-aligned target traps instead of redirecting.
  assign misaligned = bus.resolve_taken && (bus.resolve_target[1:0] != 2'b00);
  assign mispredict = (bus.resolve_taken != bus.resolve_pred) && !misaligned;
  assign next_pc    = bus.resolve_taken ? bus.resolve_target
                                        : bus.resolve_pc + XLEN'(PC_STEP);
  assign accept     = bus.resolve_valid && ready_c;

  // Next-state, flush countdown and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    redir_pc_nxt  = redir_pc_q;
    ready_c       = 1'b0;
    redir_valid_c = 1'b0;
    flush_c       = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (accept && mispredict) begin
          redir_pc_nxt = next_pc;
          state_nxt    = REDIRECT;
        end
      end
      REDIRECT: begin
        redir_valid_c = 1'b1;
        flush_c       = 1'b1;
        // Counter holds remaining FLUSH cycles minus one, so FLUSH lasts FLUSH_CYCLES.
        if (bus.redir_ready) begin
          flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
          state_nxt     = FLUSH;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (flush_cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.resolve_ready = ready_c;
  assign bus.redir_valid   = redir_valid_c;
  assign bus.redir_pc      = redir_pc_q;
  assign flush_if          = flush_c;
  assign flush_id          = flush_c;

  // State, flush counter and redirect target registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      flush_cnt  <= 4'd0;
      redir_pc_q <= '0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      redir_pc_q <= redir_pc_nxt;
    end
  end

  // One-cycle exception pulse; the offending address stays until the next trap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_exc <= 1'b0;
      exc_addr     <= '0;
    end else begin
      misalign_exc <= accept && misaligned;
      if (accept && misaligned) begin
        exc_addr <= bus.resolve_target;
      end
    end
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  // Saturating event counters for accepted branches and mispredicts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      if (accept && (branch_count != 32'hFFFF_FFFF)) begin
        branch_count <= branch_count + 32'd1;
      end
      if (accept && mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end
`else
  assign branch_count     = 32'd0;
  assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// tb/tb_branch_redirect.sv - directed self-checking bench for branch_redirect
module tb_branch_redirect;

  logic        clk;
  logic        reset_n;
  logic        flush_if;
  logic        flush_id;
  logic        misalign_exc;
  logic [31:0] exc_addr;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  int          passed;
  int          total;

  branch_redirect_if #(.XLEN(32)) bus ();

  branch_redirect #(.XLEN(32), .FLUSH_CYCLES(2), .PC_STEP(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .misalign_exc     (misalign_exc),
    .exc_addr         (exc_addr),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted resolutions must carry known taken/pred values.
  always @(posedge clk) begin
    if (reset_n && bus.resolve_valid && bus.resolve_ready) begin
      assert (!$isunknown({bus.resolve_taken, bus.resolve_pred}))
        else $error("unknown taken/pred on accepted resolution");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic drive(input bit v, input bit t, input bit p, input logic [31:0] pc, input logic [31:0] tg);
    bus.resolve_valid  = v;
    bus.resolve_taken  = t;
    bus.resolve_pred   = p;
    bus.resolve_pc     = pc;
    bus.resolve_target = tg;
  endtask

  // Presents one branch, then waits for the block to return to idle.
  task automatic send_branch(input bit t, input bit p, input logic [31:0] pc, input logic [31:0] tg, output bit ok);
    int n;
    ok = 1'b0;
    @(negedge clk);
    drive(1'b1, t, p, pc, tg);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (n = 0; n < 30; n++) begin
      if (bus.resolve_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.redir_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    total++; if (bus.redir_valid !== 1'b0) $display("FAIL reset_redir_valid got %0h want 0", bus.redir_valid); else passed++;
    total++; if ({flush_if, flush_id} !== 2'b00) $display("FAIL reset_flush got %0h want 0", {flush_if, flush_id}); else passed++;
    total++; if (bus.redir_pc !== 32'h0) $display("FAIL reset_redir_pc got %0h want 0", bus.redir_pc); else passed++;
    total++; if ({misalign_exc, exc_addr} !== 33'h0) $display("FAIL reset_exc got %0h want 0", {misalign_exc, exc_addr}); else passed++;
    total++; if ({branch_count, mispredict_count} !== 64'h0) $display("FAIL reset_counts got %0h want 0", {branch_count, mispredict_count}); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (bus.resolve_ready !== 1'b1) $display("FAIL reset_ready got %0h want 1", bus.resolve_ready); else passed++;
  endtask

  task automatic test_mispredict_taken;
    int rv, fl, nr;
    logic [31:0] pc_seen;
    rv = 0; fl = 0; nr = 0; pc_seen = 32'hDEAD_BEEF;
    bus.redir_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (bus.redir_valid === 1'b1) begin rv++; pc_seen = bus.redir_pc; end
      if (flush_if === 1'b1 && flush_id === 1'b1) fl++;
      if (bus.resolve_ready === 1'b0) nr++;
    end
    total++; if (rv !== 1) $display("FAIL mp_taken_redir_cycles got %0d want 1", rv); else passed++;
    total++; if (pc_seen !== 32'h200) $display("FAIL mp_taken_redir_pc got %0h want 200", pc_seen); else passed++;
    total++; if (fl !== 3) $display("FAIL mp_taken_flush_cycles got %0d want 3", fl); else passed++;
    total++; if (nr !== 3) $display("FAIL mp_taken_notready_cycles got %0d want 3", nr); else passed++;
  endtask

  task automatic test_redirect_stall;
    int rv, fl, bad;
    rv = 0; fl = 0; bad = 0;
    bus.redir_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_2000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (flush_if === 1'b1 && flush_id === 1'b1) fl++;
      if (bus.redir_valid === 1'b1) begin
        rv++;
        if (bus.redir_pc !== 32'h0000_1004) bad++;
        if (rv == 5) bus.redir_ready = 1'b1;
      end
    end
    bus.redir_ready = 1'b1;
    total++; if (rv !== 5) $display("FAIL stall_redir_cycles got %0d want 5", rv); else passed++;
    total++; if (bad !== 0) $display("FAIL stall_redir_pc_unstable got %0d bad cycles want 0", bad); else passed++;
    total++; if (fl !== 7) $display("FAIL stall_flush_cycles got %0d want 7", fl); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] tg [4];
    bit          tk [4];
    int notready, act;
    tg = '{32'h300, 32'h0, 32'h304, 32'h0};
    tk = '{1'b1, 1'b0, 1'b1, 1'b0};
    notready = 0; act = 0;
    @(negedge clk);
    drive(1'b1, tk[0], tk[0], 32'h10, tg[0]);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus.resolve_ready !== 1'b1) notready++;
      if (bus.redir_valid !== 1'b0 || flush_if !== 1'b0 || flush_id !== 1'b0 || misalign_exc !== 1'b0) act++;
      if (k < 4) drive(1'b1, tk[k], tk[k], 32'h10 + 32'(k * 4), tg[k]);
      else drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    total++; if (notready !== 0) $display("FAIL b2b_ready_drop got %0d cycles want 0", notready); else passed++;
    total++; if (act !== 0) $display("FAIL b2b_spurious_action got %0d cycles want 0", act); else passed++;
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h500, 32'h202);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (misalign_exc !== 1'b1) $display("FAIL misalign_pulse got %0h want 1", misalign_exc); else passed++;
    total++; if (exc_addr !== 32'h202) $display("FAIL misalign_addr got %0h want 202", exc_addr); else passed++;
    total++; if ({bus.redir_valid, flush_if, bus.resolve_ready} !== 3'b001) $display("FAIL misalign_no_redirect got %0b want 001", {bus.redir_valid, flush_if, bus.resolve_ready}); else passed++;
    @(negedge clk);
    total++; if (misalign_exc !== 1'b0) $display("FAIL misalign_one_cycle got %0h want 0", misalign_exc); else passed++;
    total++; if (flush_if !== 1'b0) $display("FAIL misalign_no_flush got %0h want 0", flush_if); else passed++;
    drive(1'b1, 1'b0, 1'b0, 32'h500, 32'h202);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if (misalign_exc !== 1'b0) $display("FAIL notaken_no_exc got %0h want 0", misalign_exc); else passed++;
    total++; if (exc_addr !== 32'h202) $display("FAIL exc_addr_held got %0h want 202", exc_addr); else passed++;
  endtask

  task automatic test_wrap_and_reset;
    bus.redir_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0040);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (bus.redir_valid !== 1'b1) $display("FAIL wrap_redir_valid got %0h want 1", bus.redir_valid); else passed++;
    total++; if (bus.redir_pc !== 32'h0) $display("FAIL wrap_redir_pc got %0h want 0", bus.redir_pc); else passed++;
    @(negedge clk);
    total++; if ({bus.redir_valid, flush_if, flush_id} !== 3'b011) $display("FAIL wrap_in_flush got %0b want 011", {bus.redir_valid, flush_if, flush_id}); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if ({bus.redir_valid, flush_if, flush_id, misalign_exc} !== 4'b0) $display("FAIL midflush_reset_ctrl got %0b want 0", {bus.redir_valid, flush_if, flush_id, misalign_exc}); else passed++;
    total++; if ({bus.redir_pc, exc_addr} !== 64'h0) $display("FAIL midflush_reset_regs got %0h want 0", {bus.redir_pc, exc_addr}); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if ({bus.resolve_ready, flush_if} !== 2'b10) $display("FAIL post_reset_idle got %0b want 10", {bus.resolve_ready, flush_if}); else passed++;
  endtask

  task automatic test_stats;
    bit          tk [10];
    bit          pr [10];
    logic [31:0] tg [10];
    bit          ok;
    int          timeouts;
    logic [31:0] exp_b, exp_m;
    tk = '{1, 0, 1, 0, 1, 1, 0, 0, 1, 1};
    pr = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1};
    tg = '{32'h300, 32'h0, 32'h200, 32'h0, 32'h310, 32'h202, 32'h0, 32'h0, 32'h320, 32'h400};
    timeouts = 0;
    bus.redir_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_branch(tk[i], pr[i], 32'h800 + 32'(i * 4), tg[i], ok);
      if (!ok) timeouts++;
    end
`ifdef BRANCH_REDIRECT_STATS_EN
    exp_b = 32'd10;
    exp_m = 32'd3;
`else
    exp_b = 32'd0;
    exp_m = 32'd0;
`endif
    total++; if (timeouts !== 0) $display("FAIL stats_idle_timeout got %0d want 0", timeouts); else passed++;
    total++; if (branch_count !== exp_b) $display("FAIL stats_branch_count got %0d want %0d", branch_count, exp_b); else passed++;
    total++; if (mispredict_count !== exp_m) $display("FAIL stats_mispredict_count got %0d want %0d", mispredict_count, exp_m); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_mispredict_taken();
    test_redirect_stall();
    test_back_to_back();
    test_misaligned();
    test_wrap_and_reset();
    test_stats();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
